ama_riscv_trace_tx: RTL and testbench
=====================================

# ama_riscv_trace_tx

Retirement trace transmitter for the core. Samples the writeback-stage retire signals and the cache hit/miss status each cycle, and buffers one entry per retired instruction in a FIFO. Entries are serialized as 3-beat packets on a 32-bit valid/ready stream. It is the producer end of the per-retire trace-entry stream (PC, instruction, I$/D$ status, cycle delta), so traces can be captured off-chip or by a stream sink without DPI.

## Interface
- FIFO_DEPTH, 8, entry buffer depth; power of 2, ≥2
- DROP_W, 16, width of drop counter
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- en  in  1  trace capture enable
- inst_retired  in  1  instruction retires this cycle
- pc_wbk  in  32  retiring PC
- inst_wbk  in  32  retiring instruction
- ic_hm  in  2  I$ status, hw_status_t: 0 none, 1 hit, 2 miss
- dc_hm  in  2  D$ status, same encoding
- tr_valid  out  1  beat valid
- tr_data  out  32  beat payload
- tr_last  out  1  final beat of packet
- tr_ready  in  1  sink accepts beat
- drop_cnt  out  DROP_W  entries dropped on full FIFO, saturating
- fifo_level  out  $clog2(FIFO_DEPTH)+1  stored entries, including the one being sent

## Operation
- Capture: in a cycle with en && inst_retired, form entry {ovf, ic_hm, dc_hm, delta[15:0], pc_wbk, inst_wbk}.
  - Write it if FIFO not full.
  - Otherwise drop it: drop_cnt += 1, saturating at all-ones; set pend_ovf.
- Full is evaluated before the same-cycle pop. A capture while full with a pop in the same cycle is dropped.
- ovf field = pend_ovf at the time of write. pend_ovf clears on any successful write.
- delta_cnt (16b, reset 0), updated only while en:
  - On a capture cycle (written or dropped): delta = min(delta_cnt+1, 0xFFFF), then delta_cnt ← 0.
  - On a non-retire cycle: delta_cnt ← min(delta_cnt+1, 0xFFFF).
  - While en=0: delta_cnt holds.
- Packet beats:
  - beat0 header: [31:28]=4'hA, [27]=ovf, [26:25]=ic_hm, [24:23]=dc_hm, [22:16]=0, [15:0]=delta.
  - beat1 = pc.
  - beat2 = inst, with tr_last=1.
- FSM states IDLE, HDR, PC, INST:
  - IDLE→HDR when FIFO non-empty.
  - HDR→PC on tr_valid&&tr_ready.
  - PC→INST on tr_valid&&tr_ready.
  - INST on handshake: pop the head, then go to HDR if another entry remains (after the pop), else IDLE.
- tr_valid=1 in HDR/PC/INST. tr_data and tr_last are driven from the state and the FIFO head.
  - They must hold stable while tr_valid && !tr_ready.
- en=0 stops capture only. Buffered entries and any in-flight packet drain normally.
- Reset (async): FIFO empty, FSM IDLE, delta_cnt=0, pend_ovf=0, drop_cnt=0.
  - Outputs: tr_valid=0, tr_last=0, tr_data=0, fifo_level=0.
  - Mid-packet reset aborts the packet immediately; no partial resume after reset.

## Timing
- Entry written at the edge ending retire cycle c. fifo_level increments visibly in cycle c+1.
- FSM leaves IDLE at the end of cycle c+1. tr_valid=1 with the header from cycle c+2 (2-cycle latency).
- With tr_ready held high, a packet takes exactly 3 cycles.
- Consecutive packets are back-to-back with no idle cycle between beat2 and the next beat0.
- Sustained throughput is 1 entry / 3 cycles. Retire rates above that fill the FIFO.
- fifo_level decrements the cycle after the beat2 handshake. Write and pop in the same cycle leave the level unchanged.
- drop_cnt updates the cycle after the dropped capture.

## Test plan
- Reset: hold rst mid-run with tr_valid=1 → tr_valid, tr_last, tr_data, fifo_level, drop_cnt all 0 immediately; after release, no beats until a new retire.
- Single retire, en=1 from reset release, retire on the 6th cycle, pc=0x40, inst=0x00000013, ic_hm=1, dc_hm=0, tr_ready=1 → beats 0xA2000006, 0x00000040, 0x00000013 (tr_last) starting 2 cycles after the retire cycle.
- Three consecutive retires, tr_ready=1 → 9 contiguous beats; headers 2 and 3 carry delta=1.
- Backpressure, FIFO_DEPTH=8, tr_ready=0, 10 consecutive retires → fifo_level=8, drop_cnt=2.
  - Then raise tr_ready for one packet and retire once more → the new entry's header has bit27=1.
  - Subsequent headers have bit27=0.
- Full with simultaneous pop: FIFO at 8, beat2 accepted in the same cycle as a retire → retire dropped, drop_cnt +1, fifo_level=7.
- Stall and enable: tr_ready toggling 1/0 → tr_data stable during each stall. en=0 with 4 entries buffered → all 4 packets sent, no new captures, delta_cnt frozen.

Source files
------------

// File: rtl/ama_riscv_trace_tx.sv
// rtl/ama_riscv_trace_tx.sv - retirement trace transmitter: entry FIFO plus 3-beat packet serializer
// One FIFO entry per retired instruction; each entry goes out as a header, PC and instruction beat.
module ama_riscv_trace_tx #(
   parameter int FIFO_DEPTH = 8,
   parameter int DROP_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          inst_retired,
   input  logic [31:0]                   pc_wbk,
   input  logic [31:0]                   inst_wbk,
   input  logic [1:0]                    ic_hm,
   input  logic [1:0]                    dc_hm,
   output logic                          tr_valid,
   output logic [31:0]                   tr_data,
   output logic                          tr_last,
   input  logic                          tr_ready,
   output logic [DROP_W-1:0]             drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PC, S_INST} state_t;

   typedef struct packed {
      logic        ovf;
      logic [1:0]  ic;
      logic [1:0]  dc;
      logic [15:0] delta;
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t              mem_q [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       count_q, count_d;
   logic [15:0]         delta_cnt_q, delta_cnt_d;
   logic                pend_ovf_q, pend_ovf_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
   state_t              state_q, state_d;

   logic                capture, full, wr, pop;
   logic [15:0]         delta_sat;
   entry_t              entry_in;
   entry_t              head;

   always_comb begin
      capture     = en && inst_retired;
      full        = (count_q == LW'(FIFO_DEPTH));
      wr          = capture && !full;
      pop         = (state_q == S_INST) && tr_ready;
      delta_sat   = (&delta_cnt_q) ? delta_cnt_q : delta_cnt_q + 16'd1;
      entry_in    = {pend_ovf_q, ic_hm, dc_hm, delta_sat, pc_wbk, inst_wbk};

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      delta_cnt_d = delta_cnt_q;
      pend_ovf_d  = pend_ovf_q;
      drop_cnt_d  = drop_cnt_q;
      state_d     = state_q;

      if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (en) delta_cnt_d = capture ? 16'd0 : delta_sat;

      // full is judged before this cycle's pop, so a capture racing a pop is still dropped
      if (capture && full) begin
         pend_ovf_d = 1'b1;
         if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
      end else if (wr) begin
         pend_ovf_d = 1'b0;
      end

      case (state_q)
         S_IDLE:  if (count_q != '0) state_d = S_HDR;
         S_HDR:   if (tr_ready) state_d = S_PC;
         S_PC:    if (tr_ready) state_d = S_INST;
         S_INST:  if (tr_ready) state_d = (count_d != '0) ? S_HDR : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         delta_cnt_q <= '0;
         pend_ovf_q  <= 1'b0;
         drop_cnt_q  <= '0;
         state_q     <= S_IDLE;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         delta_cnt_q <= delta_cnt_d;
         pend_ovf_q  <= pend_ovf_d;
         drop_cnt_q  <= drop_cnt_d;
         state_q     <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= entry_in;
   end

   // head only moves on pop, so beats stay stable while the sink stalls
   always_comb begin
      head = mem_q[rd_ptr_q];
      case (state_q)
         S_HDR:   tr_data = {4'hA, head.ovf, head.ic, head.dc, 7'd0, head.delta};
         S_PC:    tr_data = head.pc;
         S_INST:  tr_data = head.inst;
         default: tr_data = 32'd0;
      endcase
   end

   assign tr_valid   = (state_q != S_IDLE);
   assign tr_last    = (state_q == S_INST);
   assign drop_cnt   = drop_cnt_q;
   assign fifo_level = count_q;

endmodule

// File: tb/tb_ama_riscv_trace_tx.sv
// tb/tb_ama_riscv_trace_tx.sv - directed self-checking bench for ama_riscv_trace_tx
// Beats are collected by a monitor; the main block drives directed steps and checks results.
module tb_ama_riscv_trace_tx;

   logic        clk = 1'b0;
   logic        rst, en, inst_retired, tr_ready;
   logic [31:0] pc_wbk, inst_wbk;
   logic [1:0]  ic_hm, dc_hm;
   logic        tr_valid, tr_last;
   logic [31:0] tr_data;
   logic [15:0] drop_cnt;
   logic [3:0]  fifo_level;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [32:0] beat_q[$];
   int          cyc_q[$];
   logic        prev_stall = 1'b0;
   logic [32:0] prev_beat = '0;

   ama_riscv_trace_tx #(.FIFO_DEPTH(8), .DROP_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .inst_retired(inst_retired),
      .pc_wbk(pc_wbk), .inst_wbk(inst_wbk), .ic_hm(ic_hm), .dc_hm(dc_hm),
      .tr_valid(tr_valid), .tr_data(tr_data), .tr_last(tr_last), .tr_ready(tr_ready),
      .drop_cnt(drop_cnt), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // samples between the falling edge and the next rising edge, when inputs and outputs are settled
   always begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && tr_valid) chk("stall_stable", {31'd0, tr_last, tr_data}, {31'd0, prev_beat});
         if (tr_valid && tr_ready) begin
            beat_q.push_back({tr_last, tr_data});
            cyc_q.push_back(cyc);
         end
         prev_stall = tr_valid && !tr_ready;
         prev_beat  = {tr_last, tr_data};
      end
   end

   task automatic drive_retire(input logic [31:0] pc, input logic [31:0] inst,
                               input logic [1:0] ic, input logic [1:0] dc);
      inst_retired = 1'b1;
      pc_wbk = pc; inst_wbk = inst; ic_hm = ic; dc_hm = dc;
      @(negedge clk);
   endtask

   task automatic wait_beats(input string tag, input int n);
      int g = 0;
      while (beat_q.size() < n && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_wait"}, 64'(beat_q.size() >= n), 64'd1);
   endtask

   task automatic exp_beat(input string tag, input logic last, input logic [31:0] data, output int c);
      logic [32:0] b;
      c = -1;
      chk({tag, "_present"}, 64'(beat_q.size() != 0), 64'd1);
      if (beat_q.size() != 0) begin
         b = beat_q.pop_front();
         c = cyc_q.pop_front();
         chk(tag, {31'd0, b}, {31'd0, last, data});
      end
   endtask

   // checks the header top half (tag nibble, ovf, I$/D$ status) plus the PC and the last beat
   task automatic exp_pkt_hi(input string tag, input logic [15:0] hi, input logic [31:0] pc, input logic [31:0] inst);
      logic [32:0] b;
      int c;
      chk({tag, "_present"}, 64'(beat_q.size() != 0), 64'd1);
      if (beat_q.size() != 0) begin
         b = beat_q.pop_front();
         c = cyc_q.pop_front();
         chk({tag, "_hdr"}, {47'd0, b[32], b[31:16]}, {47'd0, 1'b0, hi});
      end
      exp_beat({tag, "_pc"}, 1'b0, pc, c);
      exp_beat({tag, "_inst"}, 1'b1, inst, c);
   endtask

   initial begin
      int c0, c;
      int g;
      rst = 1'b1; en = 1'b0; inst_retired = 1'b0; tr_ready = 1'b1;
      pc_wbk = '0; inst_wbk = '0; ic_hm = '0; dc_hm = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(tr_valid), 64'd0);
      chk("rst_last", 64'(tr_last), 64'd0);
      chk("rst_data", 64'(tr_data), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);

      // single retire on the 6th enabled cycle
      en = 1'b1; rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      drive_retire(32'h40, 32'h00000013, 2'd1, 2'd0);
      inst_retired = 1'b0;
      chk("single_level_c1", 64'(fifo_level), 64'd1);
      chk("single_valid_c1", 64'(tr_valid), 64'd0);
      @(negedge clk);
      chk("single_b0", {31'd0, tr_valid, tr_last, tr_data}, {31'd0, 2'b10, 32'hA2000006});
      @(negedge clk);
      chk("single_b1", {31'd0, tr_valid, tr_last, tr_data}, {31'd0, 2'b10, 32'h00000040});
      @(negedge clk);
      chk("single_b2", {31'd0, tr_valid, tr_last, tr_data}, {31'd0, 2'b11, 32'h00000013});
      @(negedge clk);
      chk("single_idle", {62'd0, tr_valid, 1'b0}, 64'd0);
      chk("single_level_end", 64'(fifo_level), 64'd0);
      beat_q.delete(); cyc_q.delete();

      // three back-to-back retires, delta_cnt was 4 when the first one lands
      drive_retire(32'h100, 32'h00100093, 2'd2, 2'd1);
      drive_retire(32'h104, 32'h00208113, 2'd1, 2'd2);
      drive_retire(32'h108, 32'h0000006F, 2'd0, 2'd0);
      inst_retired = 1'b0;
      wait_beats("three", 9);
      exp_beat("three_p0_hdr", 1'b0, 32'hA4800005, c0);
      exp_beat("three_p0_pc", 1'b0, 32'h100, c);   chk("three_contig1", 64'(c), 64'(c0 + 1));
      exp_beat("three_p0_inst", 1'b1, 32'h00100093, c); chk("three_contig2", 64'(c), 64'(c0 + 2));
      exp_beat("three_p1_hdr", 1'b0, 32'hA3000001, c); chk("three_contig3", 64'(c), 64'(c0 + 3));
      exp_beat("three_p1_pc", 1'b0, 32'h104, c);   chk("three_contig4", 64'(c), 64'(c0 + 4));
      exp_beat("three_p1_inst", 1'b1, 32'h00208113, c); chk("three_contig5", 64'(c), 64'(c0 + 5));
      exp_beat("three_p2_hdr", 1'b0, 32'hA0000001, c); chk("three_contig6", 64'(c), 64'(c0 + 6));
      exp_beat("three_p2_pc", 1'b0, 32'h108, c);   chk("three_contig7", 64'(c), 64'(c0 + 7));
      exp_beat("three_p2_inst", 1'b1, 32'h0000006F, c); chk("three_contig8", 64'(c), 64'(c0 + 8));
      repeat (2) @(negedge clk);
      chk("three_level_end", 64'(fifo_level), 64'd0);

      // backpressure: 10 retires into an 8-deep FIFO
      tr_ready = 1'b0;
      for (int i = 0; i < 10; i++) drive_retire(32'h200 + 32'(4 * i), 32'h00000013, 2'd1, 2'd1);
      inst_retired = 1'b0;
      chk("bp_level_full", 64'(fifo_level), 64'd8);
      chk("bp_drop2", 64'(drop_cnt), 64'd2);
      tr_ready = 1'b1;
      repeat (3) @(negedge clk);
      tr_ready = 1'b0;
      chk("bp_level_after_one", 64'(fifo_level), 64'd7);
      drive_retire(32'h300, 32'h00000013, 2'd1, 2'd1);
      inst_retired = 1'b0;
      chk("bp_level_refill", 64'(fifo_level), 64'd8);
      tr_ready = 1'b1;
      wait_beats("bp", 27);
      exp_pkt_hi("bp_pkt0", 16'hA280, 32'h200, 32'h13);
      for (int i = 1; i < 8; i++) exp_pkt_hi($sformatf("bp_pkt%0d", i), 16'hA280, 32'h200 + 32'(4 * i), 32'h13);
      exp_pkt_hi("bp_pkt_ovf", 16'hAA80, 32'h300, 32'h13);
      drive_retire(32'h304, 32'h00000013, 2'd1, 2'd1);
      inst_retired = 1'b0;
      wait_beats("bp_after", 3);
      exp_pkt_hi("bp_ovf_cleared", 16'hA280, 32'h304, 32'h13);
      repeat (2) @(negedge clk);

      // full FIFO with a retire in the same cycle as the beat2 handshake
      tr_ready = 1'b0;
      for (int i = 0; i < 8; i++) drive_retire(32'h400 + 32'(4 * i), 32'h00000033, 2'd2, 2'd2);
      inst_retired = 1'b0;
      chk("fp_level_full", 64'(fifo_level), 64'd8);
      tr_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("fp_in_inst", 64'(tr_last), 64'd1);
      inst_retired = 1'b1; pc_wbk = 32'h500; inst_wbk = 32'h13; ic_hm = 2'd0; dc_hm = 2'd0;
      @(negedge clk);
      inst_retired = 1'b0; tr_ready = 1'b0;
      chk("fp_drop3", 64'(drop_cnt), 64'd3);
      chk("fp_level7", 64'(fifo_level), 64'd7);

      // drain with tr_ready toggling; the monitor checks beat stability on every stall
      g = 0;
      while (beat_q.size() < 24 && g < 500) begin
         tr_ready = ~tr_ready;
         @(negedge clk);
         g++;
      end
      tr_ready = 1'b1;
      chk("stall_drain_done", 64'(beat_q.size()), 64'd24);
      for (int i = 0; i < 8; i++) exp_pkt_hi($sformatf("stall_pkt%0d", i), 16'hA500, 32'h400 + 32'(4 * i), 32'h33);
      repeat (3) @(negedge clk);
      chk("stall_level_end", 64'(fifo_level), 64'd0);

      // buffer 4 entries, then disable capture and drain
      beat_q.delete(); cyc_q.delete();
      tr_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_retire(32'h600 + 32'(4 * i), 32'h00000073, 2'd0, 2'd2);
      en = 1'b0;
      pc_wbk = 32'h700;
      repeat (5) @(negedge clk);
      chk("en0_level4", 64'(fifo_level), 64'd4);
      inst_retired = 1'b0;
      tr_ready = 1'b1;
      wait_beats("en0", 12);
      repeat (10) @(negedge clk);
      chk("en0_beat_count", 64'(beat_q.size()), 64'd12);
      chk("en0_level_end", 64'(fifo_level), 64'd0);
      exp_pkt_hi("en0_pkt0", 16'hA900, 32'h600, 32'h73);
      for (int i = 1; i < 4; i++) exp_pkt_hi($sformatf("en0_pkt%0d", i), 16'hA100, 32'h600 + 32'(4 * i), 32'h73);
      en = 1'b1;
      drive_retire(32'h800, 32'h00000013, 2'd0, 2'd0);
      inst_retired = 1'b0;
      wait_beats("en1", 3);
      exp_beat("en1_delta_frozen", 1'b0, 32'hA0000001, c);
      exp_beat("en1_pc", 1'b0, 32'h800, c);
      exp_beat("en1_inst", 1'b1, 32'h13, c);
      repeat (2) @(negedge clk);

      // asynchronous reset in the middle of a stalled packet
      tr_ready = 1'b0;
      drive_retire(32'h900, 32'h00000013, 2'd1, 2'd0);
      inst_retired = 1'b0;
      @(negedge clk);
      chk("mid_valid_before", 64'(tr_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(tr_valid), 64'd0);
      chk("mid_rst_last", 64'(tr_last), 64'd0);
      chk("mid_rst_data", 64'(tr_data), 64'd0);
      chk("mid_rst_level", 64'(fifo_level), 64'd0);
      chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0; tr_ready = 1'b1;
      beat_q.delete(); cyc_q.delete();
      repeat (20) @(negedge clk);
      chk("mid_no_resume", 64'(beat_q.size()), 64'd0);
      chk("mid_idle_valid", 64'(tr_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
